// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg: shared constants for the skid buffer slice
package skid_buffer_pkg;
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/skid_buffer_stage.sv
// skid_buffer_stage: one valid+data register with load/clear enables
module skid_buffer_stage
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready register slice with fully registered outputs
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             in_fire, main_free, main_load, main_clear, skid_load, skid_clear, skid_next;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data, main_d;
  // rst_n is active-high despite its name
  always_comb begin
    in_fire    = in_valid & in_ready;
    main_free  = !out_valid | out_ready;
    main_load  = main_free & (skid_valid | in_fire);
    main_clear = main_free & !skid_valid & !in_fire;
    main_d     = skid_valid ? skid_data : in_data;
    skid_load  = !main_free & in_fire;
    skid_clear = main_free & skid_valid;
    skid_next  = skid_load | (skid_valid & !skid_clear);
  end
  skid_buffer_stage #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .rst(rst_n), .load(main_load), .clear(main_clear),
    .d(main_d), .valid(out_valid), .data(out_data)
  );
  skid_buffer_stage #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .rst(rst_n), .load(skid_load), .clear(skid_clear),
    .d(in_data), .valid(skid_valid), .data(skid_data)
  );
  always_ff @(posedge clk) begin
    if (rst_n) in_ready <= 1'b1;
    else       in_ready <= !skid_next;
  end
endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed vectors plus random valid/ready order scoreboard
module tb_skid_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp;

  skid_buffer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b0;
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 1);
    check("rst_od", out_data, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = i;
      tick();
      check("pass_ov", out_valid, 1);
      check("pass_od", out_data, i);
      check("pass_ir", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("pass_empty", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hAAAA;
    tick();
    check("stall_a_od", out_data, 32'hAAAA);
    check("stall_a_ir", in_ready, 1);
    in_data = 32'hBBBB;
    tick();
    check("stall_b_od", out_data, 32'hAAAA);
    check("stall_b_ir", in_ready, 0);
    in_data = 32'hDEAD;
    repeat (2) begin
      tick();
      check("hold_ov", out_valid, 1);
      check("hold_od", out_data, 32'hAAAA);
      check("hold_ir", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("drain_b_od", out_data, 32'hBBBB);
    check("drain_b_ov", out_valid, 1);
    check("drain_b_ir", in_ready, 1);
    tick();
    check("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    check("full_ir", in_ready, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_ir", in_ready, 1);
    check("mid_rst_od", out_data, 0);
    for (int i = 0; i < 400; i++) begin
      in_valid = i < 397 ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = i < 397 ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = $urandom;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand_spurious", out_valid, 0);
        else begin
          exp = q.pop_front();
          check("rand_order", out_data, exp);
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
      check("rand_ov", out_valid, q.size() != 0);
      check("rand_ir", in_ready, q.size() < 2);
    end
    check("rand_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
